// File: rtl/port_allocator_pipe.sv
// Two-stage deflection-routing port allocator: rank-ordered, lowest-port-first, 2-cycle latency.
// No backpressure: a new flit set is accepted every cycle and every valid flit leaves on some port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_PORT
`define NUM_PORT 4
`endif

module port_allocator_pipe #(
    parameter int DEFL_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [`DATA_WIDTH-1:0]    rank0_data,
    input  logic [`DATA_WIDTH-1:0]    rank1_data,
    input  logic [`DATA_WIDTH-1:0]    rank2_data,
    input  logic [`DATA_WIDTH-1:0]    rank3_data,
    input  logic [`NUM_PORT-1:0]      rank0_ppv,
    input  logic [`NUM_PORT-1:0]      rank1_ppv,
    input  logic [`NUM_PORT-1:0]      rank2_ppv,
    input  logic [`NUM_PORT-1:0]      rank3_ppv,
    input  logic [3:0]                rank_valid,
    input  logic                      clr_stats,
    output logic [`DATA_WIDTH-1:0]    out0_data,
    output logic [`DATA_WIDTH-1:0]    out1_data,
    output logic [`DATA_WIDTH-1:0]    out2_data,
    output logic [`DATA_WIDTH-1:0]    out3_data,
    output logic [3:0]                out_valid,
    output logic [2:0]                defl_cnt,
    output logic [DEFL_CNT_WIDTH-1:0] defl_total
);
    localparam int DW = `DATA_WIDTH;
    localparam int NP = `NUM_PORT;

    logic [DW-1:0]             s1_data_d [4];
    logic [DW-1:0]             s1_data_q [4];
    logic [NP-1:0]             s1_ppv_d  [4];
    logic [NP-1:0]             s1_ppv_q  [4];
    logic [3:0]                s1_vld_d, s1_vld_q;
    logic [DW-1:0]             out_data_d [4];
    logic [DW-1:0]             out_data_q [4];
    logic [3:0]                out_vld_d, out_vld_q;
    logic [2:0]                defl_cnt_d, defl_cnt_q;
    logic [DEFL_CNT_WIDTH-1:0] defl_total_d, defl_total_q;
    logic [DEFL_CNT_WIDTH:0]   total_sum;
    logic [NP-1:0]             free;
    logic [NP-1:0]             cand;
    logic [1:0]                port;

    function automatic logic [1:0] lowest_set(input logic [NP-1:0] v);
        lowest_set = 2'd0;
        for (int p = NP - 1; p >= 0; p--) begin
            if (v[p]) lowest_set = p[1:0];
        end
    endfunction

    always_comb begin
        s1_data_d[0] = rank0_data;
        s1_data_d[1] = rank1_data;
        s1_data_d[2] = rank2_data;
        s1_data_d[3] = rank3_data;
        s1_ppv_d[0]  = rank0_ppv;
        s1_ppv_d[1]  = rank1_ppv;
        s1_ppv_d[2]  = rank2_ppv;
        s1_ppv_d[3]  = rank3_ppv;
        s1_vld_d     = rank_valid;
    end

    // Ranks claim ports in priority order; with <=4 flits a free port always remains.
    always_comb begin
        free       = '1;
        cand       = '0;
        port       = 2'd0;
        out_vld_d  = '0;
        defl_cnt_d = '0;
        for (int o = 0; o < 4; o++) out_data_d[o] = '0;
        for (int i = 0; i < 4; i++) begin
            if (s1_vld_q[i]) begin
                cand = s1_ppv_q[i] & free;
                if (cand == '0) begin
                    cand       = free;
                    defl_cnt_d = defl_cnt_d + 3'd1;
                end
                port             = lowest_set(cand);
                free[port]       = 1'b0;
                out_vld_d[port]  = 1'b1;
                out_data_d[port] = s1_data_q[i];
            end
        end
    end

    always_comb begin
        total_sum = {1'b0, defl_total_q} + {{(DEFL_CNT_WIDTH-2){1'b0}}, defl_cnt_d};
        if (clr_stats) begin
            defl_total_d = '0;
        end else if (total_sum[DEFL_CNT_WIDTH]) begin
            defl_total_d = '1;
        end else begin
            defl_total_d = total_sum[DEFL_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                s1_data_q[i]  <= '0;
                s1_ppv_q[i]   <= '0;
                out_data_q[i] <= '0;
            end
            s1_vld_q     <= '0;
            out_vld_q    <= '0;
            defl_cnt_q   <= '0;
            defl_total_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                s1_data_q[i]  <= s1_data_d[i];
                s1_ppv_q[i]   <= s1_ppv_d[i];
                out_data_q[i] <= out_data_d[i];
            end
            s1_vld_q     <= s1_vld_d;
            out_vld_q    <= out_vld_d;
            defl_cnt_q   <= defl_cnt_d;
            defl_total_q <= defl_total_d;
        end
    end

    assign out0_data  = out_data_q[0];
    assign out1_data  = out_data_q[1];
    assign out2_data  = out_data_q[2];
    assign out3_data  = out_data_q[3];
    assign out_valid  = out_vld_q;
    assign defl_cnt   = defl_cnt_q;
    assign defl_total = defl_total_q;
endmodule

// File: tb/tb_port_allocator_pipe.sv
// Bench for port_allocator_pipe: directed flit sets against a per-set allocation model,
// checked every cycle, plus literal expectations for the hand-worked cases.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_PORT
`define NUM_PORT 4
`endif

module tb_port_allocator_pipe;
    localparam int DW = `DATA_WIDTH;
    localparam int NP = `NUM_PORT;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data [4];
    logic [NP-1:0] in_ppv  [4];
    logic [3:0]    rank_valid;
    logic          clr_stats;

    logic [DW-1:0] o0, o1, o2, o3;
    logic [3:0]    o_vld;
    logic [2:0]    o_defl;
    logic [15:0]   o_tot;
    logic [DW-1:0] p0, p1, p2, p3;
    logic [3:0]    p_vld;
    logic [2:0]    p_defl;
    logic [3:0]    p_tot;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: the set held in stage 1 and the outputs it must produce.
    logic [DW-1:0] m_data [4];
    logic [NP-1:0] m_ppv  [4];
    logic [3:0]    m_vld;
    logic [DW-1:0] e_data [4];
    logic [3:0]    e_vld;
    int            e_defl;
    int            e_tot, e_tot4;

    always #5 clk = ~clk;

    port_allocator_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .rank0_data(in_data[0]), .rank1_data(in_data[1]),
        .rank2_data(in_data[2]), .rank3_data(in_data[3]),
        .rank0_ppv(in_ppv[0]), .rank1_ppv(in_ppv[1]),
        .rank2_ppv(in_ppv[2]), .rank3_ppv(in_ppv[3]),
        .rank_valid(rank_valid), .clr_stats(clr_stats),
        .out0_data(o0), .out1_data(o1), .out2_data(o2), .out3_data(o3),
        .out_valid(o_vld), .defl_cnt(o_defl), .defl_total(o_tot)
    );

    port_allocator_pipe #(.DEFL_CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .rank0_data(in_data[0]), .rank1_data(in_data[1]),
        .rank2_data(in_data[2]), .rank3_data(in_data[3]),
        .rank0_ppv(in_ppv[0]), .rank1_ppv(in_ppv[1]),
        .rank2_ppv(in_ppv[2]), .rank3_ppv(in_ppv[3]),
        .rank_valid(rank_valid), .clr_stats(clr_stats),
        .out0_data(p0), .out1_data(p1), .out2_data(p2), .out3_data(p3),
        .out_valid(p_vld), .defl_cnt(p_defl), .defl_total(p_tot)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Each rank picks the first wanted port nobody above it took; failing that, the first untaken port.
    task automatic model_alloc();
        bit taken [4];
        int chosen;
        for (int p = 0; p < 4; p++) begin
            taken[p]  = 1'b0;
            e_data[p] = '0;
        end
        e_vld  = '0;
        e_defl = 0;
        for (int r = 0; r < 4; r++) begin
            if (m_vld[r]) begin
                chosen = -1;
                for (int p = 0; p < 4; p++)
                    if (chosen < 0 && m_ppv[r][p] && !taken[p]) chosen = p;
                if (chosen < 0) begin
                    e_defl++;
                    for (int p = 0; p < 4; p++)
                        if (chosen < 0 && !taken[p]) chosen = p;
                end
                taken[chosen]  = 1'b1;
                e_vld[chosen]  = 1'b1;
                e_data[chosen] = m_data[r];
            end
        end
    endtask

    // One clock: advance the model at the edge, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i] = '0;
                m_ppv[i]  = '0;
                e_data[i] = '0;
            end
            m_vld = '0; e_vld = '0; e_defl = 0; e_tot = 0; e_tot4 = 0;
        end else begin
            model_alloc();
            if (clr_stats) begin
                e_tot = 0; e_tot4 = 0;
            end else begin
                e_tot  = (e_tot + e_defl > 65535) ? 65535 : e_tot + e_defl;
                e_tot4 = (e_tot4 + e_defl > 15) ? 15 : e_tot4 + e_defl;
            end
            for (int i = 0; i < 4; i++) begin
                m_data[i] = in_data[i];
                m_ppv[i]  = in_ppv[i];
            end
            m_vld = rank_valid;
        end
        @(negedge clk);
        check("out_valid", 64'(o_vld), 64'(e_vld));
        check("out0_data", 64'(o0), 64'(e_data[0]));
        check("out1_data", 64'(o1), 64'(e_data[1]));
        check("out2_data", 64'(o2), 64'(e_data[2]));
        check("out3_data", 64'(o3), 64'(e_data[3]));
        check("defl_cnt", 64'(o_defl), 64'(e_defl));
        check("defl_total", 64'(o_tot), 64'(e_tot));
        check("defl_total_w4", 64'(p_tot), 64'(e_tot4));
        check("out_valid_w4", 64'(p_vld), 64'(e_vld));
    endtask

    function automatic logic [DW-1:0] dat(input int tag, input int r);
        return DW'(32'hD000_0000 | (tag << 8) | r);
    endfunction

    task automatic drive(input int tag, input logic [3:0] v, input logic [NP-1:0] q0,
                         input logic [NP-1:0] q1, input logic [NP-1:0] q2, input logic [NP-1:0] q3);
        for (int r = 0; r < 4; r++) in_data[r] = dat(tag, r);
        in_ppv[0] = q0; in_ppv[1] = q1; in_ppv[2] = q2; in_ppv[3] = q3;
        rank_valid = v;
    endtask

    task automatic idle();
        drive(255, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    endtask

    initial begin
        reset_n = 1'b0; clr_stats = 1'b0;
        drive(1, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
        step(); step();
        check("reset_out_valid", 64'(o_vld), 64'h0);
        check("reset_defl_total", 64'(o_tot), 64'h0);
        reset_n = 1'b1;

        // Every flit gets its own productive port.
        drive(2, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
        step(); idle(); step();
        check("t026_valid", 64'(o_vld), 64'hF);
        check("t026_out0", 64'(o0), 64'(dat(2, 0)));
        check("t026_out3", 64'(o3), 64'(dat(2, 3)));
        check("t026_defl", 64'(o_defl), 64'h0);

        // All want port 0: three deflections.
        drive(3, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
        step(); idle(); step();
        check("t027_valid", 64'(o_vld), 64'hF);
        check("t027_out2", 64'(o2), 64'(dat(3, 2)));
        check("t027_defl", 64'(o_defl), 64'h3);
        check("t027_total", 64'(o_tot), 64'h3);

        // Invalid ranks carry junk that must be ignored.
        drive(4, 4'b0101, 4'b0100, 4'b1111, 4'b0110, 4'b1111);
        step(); idle(); step();
        check("t028_valid", 64'(o_vld), 64'h6);
        check("t028_out1", 64'(o1), 64'(dat(4, 2)));
        check("t028_out2", 64'(o2), 64'(dat(4, 0)));
        check("t028_out0_zero", 64'(o0), 64'h0);
        check("t028_out3_zero", 64'(o3), 64'h0);
        check("t028_defl", 64'(o_defl), 64'h0);

        // Valid flit with empty ppv deflects to the first free port.
        drive(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(); idle(); step();
        check("ppv0_valid", 64'(o_vld), 64'h1);
        check("ppv0_defl", 64'(o_defl), 64'h1);
        check("ppv0_total", 64'(o_tot), 64'h4);

        // Narrow counter saturates at 15 and holds; clear wins over live deflections.
        for (int k = 0; k < 6; k++) begin
            drive(6 + k, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
            step();
        end
        step();
        check("t029_sat", 64'(p_tot), 64'hF);
        check("t029_wide", 64'(o_tot), 64'd22);
        step();
        check("t029_hold", 64'(p_tot), 64'hF);
        clr_stats = 1'b1;
        check("t029_defl_live", 64'(dut4.defl_cnt), 64'h3);
        step();
        clr_stats = 1'b0;
        check("t029_clr", 64'(p_tot), 64'h0);
        check("t029_clr_wide", 64'(o_tot), 64'h0);
        idle(); step(); step(); step();

        // Stream, reset for one cycle mid-stream, then a marker set after release.
        for (int k = 0; k < 5; k++) begin
            drive(20 + k, 4'(k + 9), 4'(k * 3 + 1), 4'(k + 2), 4'b0001, 4'(k * 5));
            step();
        end
        reset_n = 1'b0;
        step();
        check("t030_rst_valid", 64'(o_vld), 64'h0);
        check("t030_rst_total", 64'(o_tot), 64'h0);
        reset_n = 1'b1;
        drive(30, 4'b1111, 4'b1000, 4'b0100, 4'b0010, 4'b0001);
        step();
        check("t030_lat1", 64'(o_vld), 64'h0);
        idle(); step();
        check("t030_lat2", 64'(o_vld), 64'hF);
        check("t030_out0", 64'(o0), 64'(dat(30, 3)));

        // Pseudo-random sets with occasional clears, checked by the model only.
        for (int k = 0; k < 150; k++) begin
            for (int r = 0; r < 4; r++) begin
                in_data[r] = DW'($urandom);
                in_ppv[r]  = NP'($urandom_range(0, 15));
            end
            rank_valid = 4'($urandom_range(0, 15));
            clr_stats  = ($urandom_range(0, 19) == 0);
            step();
        end
        clr_stats = 1'b0;
        idle(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/port_allocator_pipe.md
PORT_ALLOCATOR_PIPE -- requirements
Module: port_allocator_pipe

Interface
REQ-001 Parameter DEFL_CNT_WIDTH, default 16, width of the saturating deflection statistics counter.
REQ-002 Flit width is `DATA_WIDTH, productive-port-vector width is `NUM_PORT (= 4 network output ports, index 0..3); both come from global.vh.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 rank0_data..rank3_data  input  `DATA_WIDTH each  flits ordered oldest-first by the upstream sorter (rank0 = highest priority).
REQ-006 rank0_ppv..rank3_ppv  input  `NUM_PORT each  productive-port vector of the same-rank flit; bit p = port p moves the flit closer to its destination.
REQ-007 rank_valid  input  4  bit i qualifies rank i flit.
REQ-008 clr_stats  input  1  synchronous clear of defl_total.
REQ-009 out0_data..out3_data  output  `DATA_WIDTH each  registered flit for output port p.
REQ-010 out_valid  output  4  bit p qualifies outp_data.
REQ-011 defl_cnt  output  3  registered count (0..4) of flits deflected in the allocation that produced the current outputs.
REQ-012 defl_total  output  DEFL_CNT_WIDTH  saturating running total of deflections.

Function
REQ-013 Stage 1 SHALL register rank{i}_data, rank{i}_ppv and rank_valid every cycle, with no hold or stall.
REQ-014 Stage 2 SHALL allocate ports combinationally from stage-1 registers and register results into out*_data, out_valid, defl_cnt; input-to-output latency is exactly 2 cycles, throughput one flit set per cycle.
REQ-015 Allocation SHALL proceed strictly in rank order 0,1,2,3; each valid flit claims exactly one port; ports claimed by a lower rank are unavailable to higher ranks.
REQ-016 For a valid flit: if (ppv & free) != 0, SHALL take the lowest-indexed port in that set (productive); otherwise SHALL take the lowest-indexed free port and count as deflected.
REQ-017 A valid flit with ppv = 0 SHALL be treated as deflected under REQ-016.
REQ-018 An invalid flit SHALL claim no port, not count as deflected, and its data/ppv SHALL be ignored.
REQ-019 With at most 4 valid flits and 4 ports, every valid flit SHALL be assigned; no flit is ever dropped.
REQ-020 Flit data SHALL pass to the assigned port unmodified (timestamp field `TIME_POS untouched).
REQ-021 Unassigned ports SHALL have out_valid bit 0 and outp_data = 0.
REQ-022 defl_total SHALL add the stage-2 deflection count each cycle, saturating at all-ones without wrap.
REQ-023 clr_stats SHALL take priority: when asserted, defl_total becomes 0 next cycle regardless of same-cycle deflections.

Reset
REQ-024 While reset_n = 0 at a clock edge, all stage-1 and stage-2 registers, out_valid, out*_data, defl_cnt and defl_total SHALL become 0.
REQ-025 Flits present in either stage when reset asserts SHALL be discarded; the first valid output after release appears 2 cycles after the first post-reset input set.

Verification
REQ-026 All four valid, ppv = 0001,0010,0100,1000 for ranks 0..3 -> after 2 cycles out_valid = 1111, outp_data = rank p data, defl_cnt = 0.
REQ-027 All four valid, every ppv = 0001 -> rank0 on port0 productive; ranks 1,2,3 on ports 1,2,3; defl_cnt = 3; defl_total increments by 3.
REQ-028 rank_valid = 0101, rank0 ppv = 0100, rank2 ppv = 0110 -> rank0 on port2, rank2 on port1, out_valid = 0110, ports 0 and 3 data = 0, defl_cnt = 0.
REQ-029 DEFL_CNT_WIDTH = 4, drive all-ppv-0001 sets for 6 cycles (3 deflections each) -> defl_total reaches 15 and holds; assert clr_stats with deflections present -> defl_total = 0 next cycle.
REQ-030 Valid sets streamed on consecutive cycles, reset_n pulled low for one cycle mid-stream -> outputs 0 on the following cycle, in-flight sets lost, next input set emerges exactly 2 cycles after reset_n returns high.
